// File: rtl/jtag_uart_tx_pump.sv
// Avalon-MM master that drains a byte FIFO into the JTAG UART write FIFO.
// It reads WSPACE from the UART control register, then issues no more writes than that credit allows.
module jtag_uart_tx_pump #(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_GAP   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        m_address,
    output logic                        m_chipselect,
    output logic                        m_read_n,
    output logic                        m_write_n,
    output logic [31:0]                 m_writedata,
    input  logic [31:0]                 m_readdata,
    input  logic                        m_waitrequest,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [LW:0]   FULL     = (LW+1)'(FIFO_DEPTH);
    localparam logic [LW:0]   CNT_ONE  = (LW+1)'(1);
    localparam logic [LW-1:0] PTR_ONE  = LW'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);

    typedef enum logic [1:0] {IDLE, RD_CTRL, WR_DATA, BACKOFF} state_t;

    state_t          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [LW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW:0]     cnt_q, cnt_d, cnt_after_pop;
    logic [6:0]      credit_q, credit_dec, wspace;
    logic [GW-1:0]   gap_q;
    logic            active_q;
    logic            cs_q, rd_n_q, wr_n_q, addr_q;
    logic [7:0]      wbyte_q, head, head_next;
    logic            push, pop;
    logic            unused_rdata;

    assign in_ready      = active_q & (cnt_q != FULL);
    assign push          = in_valid & in_ready;
    assign pop           = (state_q == WR_DATA) & ~m_waitrequest;
    assign cnt_after_pop = cnt_q - CNT_ONE;
    assign credit_dec    = credit_q - 7'd1;
    assign wspace        = m_readdata[22:16];
    assign head          = mem_q[rd_ptr_q];
    assign head_next     = mem_q[rd_ptr_q + PTR_ONE];
    assign unused_rdata  = ^{m_readdata[31:23], m_readdata[15:0]};

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_read_n     = rd_n_q;
    assign m_write_n    = wr_n_q;
    assign m_writedata  = {24'b0, wbyte_q};
    assign busy         = (state_q != IDLE) | (cnt_q != '0);
    assign fifo_level   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (pop && !push)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            active_q <= 1'b1;
            cnt_q    <= cnt_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Bus outputs are set on the edge that enters a state, so they are valid for the whole stay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            gap_q    <= '0;
            cs_q     <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            addr_q   <= 1'b0;
            wbyte_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && cnt_q != '0) begin
                        cs_q <= 1'b1;
                        if (credit_q == '0) begin
                            state_q <= RD_CTRL;
                            rd_n_q  <= 1'b0;
                            addr_q  <= 1'b1;
                        end else begin
                            state_q <= WR_DATA;
                            wr_n_q  <= 1'b0;
                            addr_q  <= 1'b0;
                            wbyte_q <= head;
                        end
                    end
                end
                RD_CTRL: begin
                    if (!m_waitrequest) begin
                        credit_q <= wspace;
                        rd_n_q   <= 1'b1;
                        addr_q   <= 1'b0;
                        if (enable && wspace != '0) begin
                            state_q <= WR_DATA;
                            wr_n_q  <= 1'b0;
                            wbyte_q <= head;
                        end else begin
                            cs_q    <= 1'b0;
                            state_q <= enable ? BACKOFF : IDLE;
                            gap_q   <= GAP_LOAD;
                        end
                    end
                end
                WR_DATA: begin
                    if (!m_waitrequest) begin
                        credit_q <= credit_dec;
                        if (credit_dec != '0 && cnt_after_pop != '0 && enable) begin
                            wbyte_q <= head_next;
                        end else if (credit_dec == '0 && cnt_after_pop != '0 && enable) begin
                            state_q <= RD_CTRL;
                            wr_n_q  <= 1'b1;
                            rd_n_q  <= 1'b0;
                            addr_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            cs_q    <= 1'b0;
                            wr_n_q  <= 1'b1;
                        end
                    end
                end
                BACKOFF: begin
                    if (gap_q == '0) begin
                        if (enable) begin
                            state_q <= RD_CTRL;
                            cs_q    <= 1'b1;
                            rd_n_q  <= 1'b0;
                            addr_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
